// File: rtl/sc_unipolar_decoder.sv
// Unipolar stochastic-to-binary decoder: counts ones over 2^LOG_LEN accepted
// samples after a start command and presents the scaled count on valid/ready.
//   state  | meaning
//   IDLE   | waiting for iStart
//   ACC    | counting accepted samples of the window
//   HOLD   | result on oValue, waiting for iReady
module sc_unipolar_decoder #(
  parameter int INWD    = 8,
  parameter int LOG_LEN = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iStart,
  input  logic            iEn,
  input  logic            iBit,
  output logic            oBusy,
  output logic [INWD-1:0] oValue,
  output logic            oValid,
  input  logic            iReady
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [LOG_LEN-1:0] SMP_ONE = LOG_LEN'(1);

  state_t             r_state;
  logic [LOG_LEN-1:0] r_smp;
  logic [LOG_LEN:0]   r_ones;

  logic [LOG_LEN:0]   w_sum;
  logic [INWD-1:0]    w_scaled;
  logic [INWD-1:0]    w_conv;
  logic               w_last;

  // The final sample is folded in on the same edge that loads oValue.
  assign w_sum    = r_ones + {{LOG_LEN{1'b0}}, iBit};
  assign w_scaled = INWD'(w_sum[LOG_LEN-1:0]) << (INWD - LOG_LEN);
  assign w_conv   = w_sum[LOG_LEN] ? {INWD{1'b1}} : w_scaled;
  assign w_last   = &r_smp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_smp   <= '0;
      r_ones  <= '0;
      oValue  <= '0;
      oValid  <= 1'b0;
      oBusy   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (iStart) begin
            r_state <= S_ACC;
            r_smp   <= '0;
            r_ones  <= '0;
            oBusy   <= 1'b1;
          end
        end
        S_ACC: begin
          if (iStart) begin
            r_smp  <= '0;
            r_ones <= '0;
          end else if (iEn) begin
            if (w_last) begin
              r_state <= S_HOLD;
              r_smp   <= '0;
              r_ones  <= '0;
              oValue  <= w_conv;
              oValid  <= 1'b1;
              oBusy   <= 1'b0;
            end else begin
              r_smp  <= r_smp + SMP_ONE;
              r_ones <= w_sum;
            end
          end
        end
        S_HOLD: begin
          // iStart only counts once the result has been taken.
          if (iReady) begin
            oValid <= 1'b0;
            if (iStart) begin
              r_state <= S_ACC;
              r_smp   <= '0;
              r_ones  <= '0;
              oBusy   <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          oValid  <= 1'b0;
          oBusy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_unipolar_decoder.sv
// Directed bench for sc_unipolar_decoder: an 8/8 instance and an 8/4 instance.
module tb_sc_unipolar_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, en8 = 1'b0, bit8 = 1'b0, ready8 = 1'b0;
  logic       busy8, valid8;
  logic [7:0] value8;

  logic       start4 = 1'b0, en4 = 1'b0, bit4 = 1'b0, ready4 = 1'b0;
  logic       busy4, valid4;
  logic [7:0] value4;

  int n_total = 0;
  int n_bad   = 0;
  int bcnt;
  int vcnt;

  always #5 clk = ~clk;

  sc_unipolar_decoder #(.INWD(8), .LOG_LEN(8)) u_dut8 (
    .clk(clk), .rst(rst), .iStart(start8), .iEn(en8), .iBit(bit8),
    .oBusy(busy8), .oValue(value8), .oValid(valid8), .iReady(ready8)
  );

  sc_unipolar_decoder #(.INWD(8), .LOG_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .iStart(start4), .iEn(en4), .iBit(bit4),
    .oBusy(busy4), .oValue(value4), .oValid(valid4), .iReady(ready4)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_8();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  // mode 0: all ones, 1: alternating 1,0, 2: all zeros
  task automatic feed_8(input int n, input int mode);
    for (int k = 0; k < n; k++) begin
      en8  = 1'b1;
      bit8 = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 2) == 0) : 1'b0;
      tick();
    end
    en8  = 1'b0;
    bit8 = 1'b0;
  endtask

  task automatic accept_8();
    ready8 = 1'b1;
    tick();
    ready8 = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    chk("rst_value", value8, 0);
    chk("rst_valid", valid8, 0);
    chk("rst_busy", busy8, 0);
    rst = 1'b0;
    tick();

    // all ones, saturating; busy width counted
    start_8();
    chk("t1_busy_after_start", busy8, 1);
    bcnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (busy8) bcnt++;
      if (i == 255) chk("t1_valid_before_last", valid8, 0);
      en8 = 1'b1;
      bit8 = 1'b1;
      tick();
    end
    en8 = 1'b0;
    chk("t1_busy_cycles", bcnt, 256);
    chk("t1_busy_end", busy8, 0);
    chk("t1_valid", valid8, 1);
    chk("t1_value", value8, 255);
    accept_8();
    chk("t1_valid_drop", valid8, 0);
    chk("t1_value_kept", value8, 255);
    chk("t1_idle_busy", busy8, 0);

    // alternating -> 128, then zeros -> 0
    start_8();
    feed_8(256, 1);
    chk("t2_valid", valid8, 1);
    chk("t2_value", value8, 128);
    accept_8();
    chk("t2_valid_drop", valid8, 0);
    start_8();
    feed_8(256, 2);
    chk("t2_zero_valid", valid8, 1);
    chk("t2_zero_value", value8, 0);
    accept_8();

    // LOG_LEN=4, iEn every other cycle, 4 ones -> 64
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (i == 16) chk("t3_valid_at_16_cycles", valid4, 0);
      if (i == 30) chk("t3_valid_before_last", valid4, 0);
      en4  = ((i % 2) == 0);
      bit4 = ((i % 2) == 0) ? (i < 8) : 1'b1;
      tick();
    end
    en4 = 1'b0;
    bit4 = 1'b0;
    chk("t3_valid", valid4, 1);
    chk("t3_value", value4, 64);
    ready4 = 1'b1;
    tick();
    ready4 = 1'b0;
    chk("t3_valid_drop", valid4, 0);

    // backpressure
    start_8();
    feed_8(256, 1);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      start8 = ((i % 2) == 0);
      en8    = 1'b1;
      bit8   = ((i % 2) == 1);
      tick();
      if (valid8 && value8 == 8'd128 && !busy8) vcnt++;
    end
    start8 = 1'b0;
    en8 = 1'b0;
    bit8 = 1'b0;
    chk("t4_hold_cycles", vcnt, 10);
    chk("t4_value_held", value8, 128);
    ready8 = 1'b1;
    start8 = 1'b1;
    tick();
    ready8 = 1'b0;
    start8 = 1'b0;
    chk("t4_busy_direct", busy8, 1);
    chk("t4_valid_drop", valid8, 0);
    feed_8(256, 0);
    chk("t4_value", value8, 255);
    chk("t4_valid", valid8, 1);
    accept_8();

    // reset mid-window
    start_8();
    feed_8(50, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", busy8, 0);
    chk("t6_valid", valid8, 0);
    chk("t6_value", value8, 0);
    vcnt = 0;
    for (int i = 0; i < 300; i++) begin
      en8 = 1'b1;
      bit8 = 1'b1;
      tick();
      if (valid8 || busy8) vcnt++;
    end
    en8 = 1'b0;
    chk("t6_no_result", vcnt, 0);

    // restart inside ACC
    start_8();
    feed_8(100, 0);
    start8 = 1'b1;
    en8 = 1'b1;
    bit8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("t5_busy_restart", busy8, 1);
    feed_8(255, 2);
    chk("t5_not_yet", valid8, 0);
    feed_8(1, 2);
    chk("t5_valid", valid8, 1);
    chk("t5_value", value8, 0);
    accept_8();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
